npu_setreset_seq: RTL

Parametrised SET/RESET/READ sequencer for the NPU_v2 wrap, succeeding the fixed three-signal WL/SEL/BL pulse timing.
- Generates NUM_CH independent pulse-window enables per SET or RESET pulse.
- Runs a programmable op list of NUM_OPS slots.
- Sweeps WL/BL address ranges with single-point (L1) and whole-range (L4) loops.
- Sits between the AXI config/status register file and the NPU pad-driver logic.

---
 rtl/npu_setreset_seq_pkg.sv | 22 ++
 rtl/npu_setreset_seq_if.sv | 63 ++++++
 rtl/npu_pulse_window.sv | 14 +
 rtl/npu_setreset_seq.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/npu_setreset_seq_pkg.sv
// Shared op/state encodings for the NPU SET/RESET/READ sequencer.
package npu_seq_pkg;

   localparam int OP_W = 2;

   typedef enum logic [OP_W-1:0] {
      OP_SET     = 2'd0,
      OP_RESET   = 2'd1,
      OP_READMEM = 2'd2,
      OP_END     = 2'd3
   } op_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_PULSE,
      S_READ,
      S_NEXT,
      S_DONE
   } state_e;

endpackage

// File: rtl/npu_setreset_seq_if.sv
// Config/status bundle between the register file and the sequencer.
// NPU_SEQ_CYCLE_CNT_EN adds the busy_cycles status counter.
interface npu_setreset_seq_if #(
   parameter int NUM_CH  = 3,
   parameter int NUM_OPS = 4,
   parameter int PW_W    = 16,
   parameter int ADDR_W  = 8,
   parameter int LOOP_W  = 32
);
   import npu_seq_pkg::*;

   logic                     start;
   logic                     stop;
   logic [OP_W*NUM_OPS-1:0]  op_list;
   logic [PW_W-1:0]          set_pw;
   logic [PW_W-1:0]          reset_pw;
   logic [NUM_CH*PW_W-1:0]   set_st;
   logic [NUM_CH*PW_W-1:0]   set_end;
   logic [NUM_CH*PW_W-1:0]   rst_st;
   logic [NUM_CH*PW_W-1:0]   rst_end;
   logic [ADDR_W-1:0]        wl_st;
   logic [ADDR_W-1:0]        wl_end;
   logic [ADDR_W-1:0]        bl_st;
   logic [ADDR_W-1:0]        bl_end;
   logic [LOOP_W-1:0]        l1_loop;
   logic [LOOP_W-1:0]        l4_loop;
   logic                     readmem_done;

   logic [NUM_CH-1:0]        ch_en;
   logic                     set_o;
   logic                     reset_o;
   logic                     readmem_req;
   logic [ADDR_W-1:0]        wl_addr;
   logic [ADDR_W-1:0]        bl_addr;
   logic                     busy;
   logic                     done;
   logic                     aborted;
   logic [OP_W-1:0]          cur_op;
`ifdef NPU_SEQ_CYCLE_CNT_EN
   logic [31:0]              busy_cycles;
`endif

   modport master (
      output start, stop, op_list, set_pw, reset_pw, set_st, set_end, rst_st, rst_end,
             wl_st, wl_end, bl_st, bl_end, l1_loop, l4_loop, readmem_done,
      input  ch_en, set_o, reset_o, readmem_req, wl_addr, bl_addr, busy, done, aborted,
`ifdef NPU_SEQ_CYCLE_CNT_EN
             busy_cycles,
`endif
             cur_op
   );

   modport slave (
      input  start, stop, op_list, set_pw, reset_pw, set_st, set_end, rst_st, rst_end,
             wl_st, wl_end, bl_st, bl_end, l1_loop, l4_loop, readmem_done,
      output ch_en, set_o, reset_o, readmem_req, wl_addr, bl_addr, busy, done, aborted,
`ifdef NPU_SEQ_CYCLE_CNT_EN
             busy_cycles,
`endif
             cur_op
   );

endinterface

// File: rtl/npu_pulse_window.sv
// One pulse-window channel: enabled while st <= cnt <= end, clipped at the pulse width.
module npu_pulse_window #(
   parameter int PW_W = 16
) (
   input  logic [PW_W-1:0] cnt_i,
   input  logic [PW_W-1:0] st_i,
   input  logic [PW_W-1:0] end_i,
   input  logic [PW_W-1:0] pw_i,
   output logic            en_o
);

   assign en_o = (cnt_i >= st_i) && (cnt_i <= end_i) && (cnt_i <= pw_i);

endmodule

// File: rtl/npu_setreset_seq.sv
// SET/RESET/READ op-list sequencer with WL/BL sweep and L1/L4 loops.
// Define NPU_SEQ_CYCLE_CNT_EN to add the saturating busy_cycles counter.
module npu_setreset_seq
   import npu_seq_pkg::*;
#(
   parameter int NUM_CH  = 3,
   parameter int NUM_OPS = 4,
   parameter int PW_W    = 16,
   parameter int ADDR_W  = 8,
   parameter int LOOP_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   npu_setreset_seq_if.slave bus
);

   localparam int SLOT_W = $clog2(NUM_OPS + 1);

   logic [OP_W*NUM_OPS-1:0] op_list_q;
   logic [PW_W-1:0]         set_pw_q, reset_pw_q;
   logic [NUM_CH*PW_W-1:0]  set_st_q, set_end_q, rst_st_q, rst_end_q;
   logic [ADDR_W-1:0]       wl_st_q, wl_end_q, bl_st_q, bl_end_q;
   logic [LOOP_W-1:0]       l1_max_q, l4_max_q;

   state_e                  state_q;
   logic [SLOT_W-1:0]       slot_q;
   logic [PW_W-1:0]         cnt_q;
   logic [LOOP_W-1:0]       l1_cnt_q, l4_cnt_q;
   logic [NUM_CH-1:0]       ch_en_q;
   logic                    set_q, reset_q, req_q, busy_q, done_q, aborted_q;
   logic [ADDR_W-1:0]       wl_addr_q, bl_addr_q;
   op_e                     cur_op_q;

   logic                    start_acc;
   op_e                     slot_op_d, next_op_d;
   logic [SLOT_W-1:0]       slot_inc_d;
   logic [LOOP_W-1:0]       l1_inc_d, l4_inc_d;
   logic                    win_set_d, bl_last_d, wl_last_d;
   logic [PW_W-1:0]         win_cnt_d, win_pw_d;
   logic [NUM_CH-1:0]       win_en_d;

   assign start_acc = (state_q == S_IDLE) && bus.start;

   // NOTE: shadow config is not reset; it is only consumed after a start has loaded it.
   always_ff @(posedge clk) begin
      if (start_acc) begin
         op_list_q  <= bus.op_list;
         set_pw_q   <= bus.set_pw;
         reset_pw_q <= bus.reset_pw;
         set_st_q   <= bus.set_st;
         set_end_q  <= bus.set_end;
         rst_st_q   <= bus.rst_st;
         rst_end_q  <= bus.rst_end;
         wl_st_q    <= bus.wl_st;
         wl_end_q   <= bus.wl_end;
         bl_st_q    <= bus.bl_st;
         bl_end_q   <= bus.bl_end;
         l1_max_q   <= (bus.l1_loop == '0) ? LOOP_W'(1) : bus.l1_loop;
         l4_max_q   <= (bus.l4_loop == '0) ? LOOP_W'(1) : bus.l4_loop;
      end
   end

   // NOTE: every output gets a default first so no path can infer a latch.
   always_comb begin
      slot_inc_d = slot_q + 1'b1;
      slot_op_d  = OP_END;
      next_op_d  = OP_END;
      for (int k = 0; k < NUM_OPS; k++) begin
         if (slot_q == SLOT_W'(k))     slot_op_d = op_e'(op_list_q[k*OP_W +: OP_W]);
         if (slot_inc_d == SLOT_W'(k)) next_op_d = op_e'(op_list_q[k*OP_W +: OP_W]);
      end
      l1_inc_d  = l1_cnt_q + 1'b1;
      l4_inc_d  = l4_cnt_q + 1'b1;
      // Window lookahead: the count the channels will show in the coming cycle.
      win_set_d = (state_q == S_PULSE) ? (cur_op_q == OP_SET) : (slot_op_d == OP_SET);
      win_cnt_d = (state_q == S_PULSE) ? cnt_q + 1'b1 : '0;
      win_pw_d  = win_set_d ? set_pw_q : reset_pw_q;
      bl_last_d = (bl_addr_q == bl_end_q) || (bl_st_q > bl_end_q);
      wl_last_d = (wl_addr_q == wl_end_q) || (wl_st_q > wl_end_q);
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      npu_pulse_window #(.PW_W(PW_W)) u_win (
         .cnt_i (win_cnt_d),
         .st_i  (win_set_d ? set_st_q[i*PW_W +: PW_W]  : rst_st_q[i*PW_W +: PW_W]),
         .end_i (win_set_d ? set_end_q[i*PW_W +: PW_W] : rst_end_q[i*PW_W +: PW_W]),
         .pw_i  (win_pw_d),
         .en_o  (win_en_d[i])
      );
   end

   // NOTE: non-blocking assignments so every branch reads pre-edge register values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         slot_q    <= '0;
         cnt_q     <= '0;
         l1_cnt_q  <= '0;
         l4_cnt_q  <= '0;
         ch_en_q   <= '0;
         set_q     <= 1'b0;
         reset_q   <= 1'b0;
         req_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
         wl_addr_q <= '0;
         bl_addr_q <= '0;
         cur_op_q  <= OP_SET;
      end else begin
         done_q <= 1'b0;
         if (state_q != S_IDLE && bus.stop) begin
            state_q   <= S_IDLE;
            ch_en_q   <= '0;
            set_q     <= 1'b0;
            reset_q   <= 1'b0;
            req_q     <= 1'b0;
            busy_q    <= 1'b0;
            aborted_q <= 1'b1;
            cur_op_q  <= OP_SET;
         end else begin
            unique case (state_q)
               S_IDLE: if (bus.start) begin
                  state_q   <= S_LOAD;
                  busy_q    <= 1'b1;
                  aborted_q <= 1'b0;
                  wl_addr_q <= bus.wl_st;
                  bl_addr_q <= bus.bl_st;
                  l1_cnt_q  <= '0;
                  l4_cnt_q  <= '0;
                  slot_q    <= '0;
               end
               S_LOAD: begin
                  cur_op_q <= slot_op_d;
                  cnt_q    <= '0;
                  case (slot_op_d)
                     OP_SET, OP_RESET: begin
                        state_q <= S_PULSE;
                        set_q   <= (slot_op_d == OP_SET);
                        reset_q <= (slot_op_d == OP_RESET);
                        ch_en_q <= win_en_d;
                     end
                     OP_READMEM: begin
                        state_q <= S_READ;
                        req_q   <= 1'b1;
                     end
                     default: begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                     end
                  endcase
               end
               S_PULSE: if (cnt_q != win_pw_d) begin
                  cnt_q   <= cnt_q + 1'b1;
                  ch_en_q <= win_en_d;
               end else begin
                  state_q <= S_NEXT;
                  ch_en_q <= '0;
                  set_q   <= 1'b0;
                  reset_q <= 1'b0;
               end
               S_READ: if (bus.readmem_done) begin
                  state_q <= S_NEXT;
                  req_q   <= 1'b0;
               end
               S_NEXT: begin
                  state_q <= S_LOAD;
                  if (next_op_d != OP_END) begin
                     slot_q <= slot_inc_d;
                  end else begin
                     slot_q <= '0;
                     if (l1_inc_d < l1_max_q) begin
                        l1_cnt_q <= l1_inc_d;
                     end else begin
                        l1_cnt_q <= '0;
                        // Point order: BL inner, WL outer, whole sweep repeated by L4.
                        if (!bl_last_d) begin
                           bl_addr_q <= bl_addr_q + 1'b1;
                        end else begin
                           bl_addr_q <= bl_st_q;
                           if (!wl_last_d) begin
                              wl_addr_q <= wl_addr_q + 1'b1;
                           end else if (l4_inc_d < l4_max_q) begin
                              l4_cnt_q  <= l4_inc_d;
                              wl_addr_q <= wl_st_q;
                           end else begin
                              state_q <= S_DONE;
                              done_q  <= 1'b1;
                           end
                        end
                     end
                  end
               end
               S_DONE: begin
                  state_q  <= S_IDLE;
                  busy_q   <= 1'b0;
                  cur_op_q <= OP_SET;
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

`ifdef NPU_SEQ_CYCLE_CNT_EN
   logic [31:0] busy_cycles_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                               busy_cycles_q <= '0;
      else if (start_acc)                      busy_cycles_q <= '0;
      else if (busy_q && busy_cycles_q != '1)  busy_cycles_q <= busy_cycles_q + 1'b1;
   end

   assign bus.busy_cycles = busy_cycles_q;
`endif

   assign bus.ch_en       = ch_en_q;
   assign bus.set_o       = set_q;
   assign bus.reset_o     = reset_q;
   assign bus.readmem_req = req_q;
   assign bus.wl_addr     = wl_addr_q;
   assign bus.bl_addr     = bl_addr_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.aborted     = aborted_q;
   assign bus.cur_op      = cur_op_q;

endmodule
